// File: rtl/stage_write_arb.sv
// Purpose: merges in-order pipeline writeback with buffered multdiv completions onto one regfile write port.
// Latency: 1 cycle from pipeline input, or from FIFO pop, to the registered write outputs.
// Backpressure: md_ready drops when the FIFO is full; the pipeline is never stalled and always wins the port.
//
// Ports:
//   clock, reset                  rising-edge clock, asynchronous active-low reset
//   pipe_valid/insn/o/d/exception writeback-stage instruction, ALU/PC+1 result, dmem data, exception flag
//   md_valid/rd/data/exception    multdiv completion strobe, destination, result/status, exception flag
//   md_ready                      FIFO has room (current occupancy only)
//   data_writeReg/ctrl_writeReg/ctrl_writeEnable  registered regfile write port
//   q_count                       FIFO occupancy, squashed entries included
module stage_write_arb #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int QDEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         pipe_valid,
    input  logic [31:0]                  pipe_insn,
    input  logic [DATA_W-1:0]            pipe_o,
    input  logic [DATA_W-1:0]            pipe_d,
    input  logic                         pipe_exception,
    input  logic                         md_valid,
    input  logic [REG_AW-1:0]            md_rd,
    input  logic [DATA_W-1:0]            md_data,
    input  logic                         md_exception,
    output logic                         md_ready,
    output logic [DATA_W-1:0]            data_writeReg,
    output logic [REG_AW-1:0]            ctrl_writeReg,
    output logic                         ctrl_writeEnable,
    output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);

    localparam logic [REG_AW-1:0] REG_LINK    = REG_AW'(31);
    localparam logic [REG_AW-1:0] REG_RSTATUS = REG_AW'(30);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    // FIFO storage; q_vld is cleared by reset and by WAW squash, payload needs no reset
    logic [REG_AW-1:0] q_dest [QDEPTH];
    logic [DATA_W-1:0] q_data [QDEPTH];
    logic [QDEPTH-1:0] q_vld;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    logic [4:0]        opcode;
    logic [REG_AW-1:0] pipe_rd;
    logic              is_jal;
    logic              is_lw;
    logic              is_setx;
    logic              op_writes;
    logic [REG_AW-1:0] pipe_dest;
    logic [DATA_W-1:0] pipe_wdata;
    logic              pipe_we;

    logic [REG_AW-1:0] md_dest;
    logic              push;
    logic              push_vld;
    logic              pop;
    logic              head_vld;

    // ALU op and immediate fields do not affect writeback routing
    logic unused_insn;
    assign unused_insn = ^pipe_insn[21:0];

    always_comb begin
        opcode     = pipe_insn[31:27];
        pipe_rd    = REG_AW'(pipe_insn[26:22]);
        is_jal     = (opcode == OP_JAL);
        is_lw      = (opcode == OP_LW);
        is_setx    = (opcode == OP_SETX);
        op_writes  = (opcode == OP_RTYPE) || (opcode == OP_ADDI) || is_lw || is_jal || is_setx;
        pipe_dest  = is_jal ? REG_LINK : ((pipe_exception || is_setx) ? REG_RSTATUS : pipe_rd);
        pipe_wdata = is_lw ? pipe_d : pipe_o;
        pipe_we    = pipe_valid && op_writes && (pipe_dest != '0);
    end

    always_comb begin
        md_ready = (q_count < CW'(QDEPTH));
        md_dest  = md_exception ? REG_RSTATUS : md_rd;
        // writes to r0 carry nothing worth keeping, so they never take a slot
        push     = md_valid && md_ready && (md_exception || (md_rd != '0));
        // a same-cycle pipeline write to the same register is newer in program order
        push_vld = !(pipe_we && (pipe_dest == md_dest));
        pop      = !pipe_we && (q_count != '0);
        head_vld = q_vld[rd_ptr];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
            q_vld   <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (pipe_we && q_vld[i] && (q_dest[i] == pipe_dest)) begin
                    q_vld[i] <= 1'b0;
                end
            end
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            // push slot is never occupied (not full), so it cannot collide with the squash loop
            if (push) begin
                q_vld[wr_ptr] <= push_vld;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + CW'(1);
                2'b01:   q_count <= q_count - CW'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            q_dest[wr_ptr] <= md_dest;
            q_data[wr_ptr] <= md_data;
        end
    end

    // A popped squashed entry burns the cycle: enable drops, address/data hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
        end else if (pipe_we) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= pipe_dest;
            data_writeReg    <= pipe_wdata;
        end else if (pop) begin
            ctrl_writeEnable <= head_vld;
            if (head_vld) begin
                ctrl_writeReg <= q_dest[rd_ptr];
                data_writeReg <= q_data[rd_ptr];
            end
        end else begin
            ctrl_writeEnable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_write_arb.sv
// Purpose: directed self-checking bench for stage_write_arb with QDEPTH = 4.
// Latency: expects outputs 1 cycle after pipeline write or FIFO pop.
// Backpressure: exercises full FIFO, drop of completions while md_ready = 0.
module tb_stage_write_arb;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_SW    = 5'b00111;

    logic        clock;
    logic        reset;
    logic        pipe_valid;
    logic [31:0] pipe_insn;
    logic [31:0] pipe_o;
    logic [31:0] pipe_d;
    logic        pipe_exception;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_exception;
    logic        md_ready;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_writeReg;
    logic        ctrl_writeEnable;
    logic [2:0]  q_count;

    int checks = 0;
    int errors = 0;

    stage_write_arb #(.DATA_W(32), .REG_AW(5), .QDEPTH(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .pipe_valid       (pipe_valid),
        .pipe_insn        (pipe_insn),
        .pipe_o           (pipe_o),
        .pipe_d           (pipe_d),
        .pipe_exception   (pipe_exception),
        .md_valid         (md_valid),
        .md_rd            (md_rd),
        .md_data          (md_data),
        .md_exception     (md_exception),
        .md_ready         (md_ready),
        .data_writeReg    (data_writeReg),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_writeEnable (ctrl_writeEnable),
        .q_count          (q_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        pipe_valid     = 1'b0;
        pipe_exception = 1'b0;
        md_valid       = 1'b0;
        md_exception   = 1'b0;
    endtask

    task automatic pwr(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] o, input logic [31:0] d);
        pipe_valid = 1'b1;
        pipe_insn  = {op, rd, 22'd0};
        pipe_o     = o;
        pipe_d     = d;
    endtask

    task automatic md(input logic [4:0] rd, input logic [31:0] data);
        md_valid = 1'b1;
        md_rd    = rd;
        md_data  = data;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle();
        pipe_insn = '0; pipe_o = '0; pipe_d = '0; md_rd = '0; md_data = '0;
        #2 reset = 1'b0;
        #1;
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== 38'd0) begin
            errors++; $display("FAIL reset_out: got %h want 0", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}); end
        checks++; if ({q_count, md_ready} !== {3'd0, 1'b1}) begin
            errors++; $display("FAIL reset_q: q_count=%0d md_ready=%0b want 0/1", q_count, md_ready); end
        step();
        step();
        reset = 1'b1;
        step();
        checks++; if (ctrl_writeEnable !== 1'b0) begin
            errors++; $display("FAIL reset_idle: we=%0b want 0", ctrl_writeEnable); end
    endtask

    task automatic test_decode;
        pwr(OP_JAL, 5'd9, 32'h40, 32'h0); step();
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd31, 32'h40}) begin
            errors++; $display("FAIL dec_jal: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd31, 32'h40}); end
        pwr(OP_LW, 5'd5, 32'h1234, 32'hDEAD); step();
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd5, 32'hDEAD}) begin
            errors++; $display("FAIL dec_lw: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd5, 32'hDEAD}); end
        pwr(OP_RTYPE, 5'd0, 32'h55, 32'h0); step();
        checks++; if (ctrl_writeEnable !== 1'b0) begin
            errors++; $display("FAIL dec_r0: we=%0b want 0", ctrl_writeEnable); end
        pwr(OP_RTYPE, 5'd12, 32'h66, 32'h0); pipe_exception = 1'b1; step();
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd30, 32'h66}) begin
            errors++; $display("FAIL dec_exc: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd30, 32'h66}); end
        pipe_exception = 1'b0;
        pwr(OP_SETX, 5'd4, 32'h77, 32'h0); step();
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd30, 32'h77}) begin
            errors++; $display("FAIL dec_setx: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd30, 32'h77}); end
        pwr(OP_SW, 5'd6, 32'h88, 32'h0); step();
        checks++; if (ctrl_writeEnable !== 1'b0) begin
            errors++; $display("FAIL dec_sw: we=%0b want 0", ctrl_writeEnable); end
        pwr(OP_ADDI, 5'd6, 32'h99, 32'h0); pipe_valid = 1'b0; step();
        checks++; if (ctrl_writeEnable !== 1'b0) begin
            errors++; $display("FAIL dec_invalid: we=%0b want 0", ctrl_writeEnable); end
        idle();
    endtask

    task automatic test_drain;
        pwr(OP_ADDI, 5'd1, 32'h101, 32'h0); md(5'd7, 32'h11); step();
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count} !== {1'b1, 5'd1, 32'h101, 3'd1}) begin
            errors++; $display("FAIL drain_p1: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count}, {1'b1, 5'd1, 32'h101, 3'd1}); end
        pwr(OP_ADDI, 5'd2, 32'h102, 32'h0); md(5'd9, 32'h22); step();
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count} !== {1'b1, 5'd2, 32'h102, 3'd2}) begin
            errors++; $display("FAIL drain_p2: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count}, {1'b1, 5'd2, 32'h102, 3'd2}); end
        pwr(OP_ADDI, 5'd4, 32'h104, 32'h0); md_valid = 1'b0; step();
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count} !== {1'b1, 5'd4, 32'h104, 3'd2}) begin
            errors++; $display("FAIL drain_p3: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count}, {1'b1, 5'd4, 32'h104, 3'd2}); end
        idle(); step();
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count} !== {1'b1, 5'd7, 32'h11, 3'd1}) begin
            errors++; $display("FAIL drain_pop1: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count}, {1'b1, 5'd7, 32'h11, 3'd1}); end
        step();
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count} !== {1'b1, 5'd9, 32'h22, 3'd0}) begin
            errors++; $display("FAIL drain_pop2: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count}, {1'b1, 5'd9, 32'h22, 3'd0}); end
        step();
        checks++; if ({ctrl_writeEnable, q_count} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL drain_empty: we=%0b q_count=%0d want 0/0", ctrl_writeEnable, q_count); end
    endtask

    task automatic test_full;
        pwr(OP_ADDI, 5'd1, 32'h1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            md(5'(10 + i), 32'hA0 + i); step();
            checks++; if (q_count !== 3'(i + 1)) begin
                errors++; $display("FAIL full_fill%0d: q_count=%0d want %0d", i, q_count, i + 1); end
        end
        checks++; if (md_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready: md_ready=%0b want 0", md_ready); end
        md(5'd14, 32'hEE); step();
        checks++; if (q_count !== 3'd4) begin
            errors++; $display("FAIL full_drop: q_count=%0d want 4", q_count); end
        idle(); step();
        checks++; if ({md_ready, q_count, ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 3'd3, 1'b1, 5'd10, 32'hA0}) begin
            errors++; $display("FAIL full_recover: got %h want %h", {md_ready, q_count, ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 3'd3, 1'b1, 5'd10, 32'hA0}); end
        for (int i = 1; i < 4; i++) begin
            step();
            checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'(10 + i), 32'hA0 + i}) begin
                errors++; $display("FAIL full_order%0d: got %h want %h", i, {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'(10 + i), 32'hA0 + i}); end
        end
        step();
        checks++; if ({ctrl_writeEnable, q_count} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL full_nodrop: we=%0b q_count=%0d want 0/0", ctrl_writeEnable, q_count); end
    endtask

    task automatic test_md_dest;
        pwr(OP_ADDI, 5'd1, 32'h1, 32'h0); md(5'd0, 32'h55); step();
        checks++; if (q_count !== 3'd0) begin
            errors++; $display("FAIL md_r0: q_count=%0d want 0", q_count); end
        md(5'd8, 32'h77); md_exception = 1'b1; step();
        checks++; if (q_count !== 3'd1) begin
            errors++; $display("FAIL md_exc_push: q_count=%0d want 1", q_count); end
        idle(); step();
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count} !== {1'b1, 5'd30, 32'h77, 3'd0}) begin
            errors++; $display("FAIL md_exc_wb: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count}, {1'b1, 5'd30, 32'h77, 3'd0}); end
    endtask

    task automatic test_squash;
        pwr(OP_ADDI, 5'd20, 32'h1, 32'h0); md(5'd3, 32'hAA); step();
        checks++; if (q_count !== 3'd1) begin
            errors++; $display("FAIL sq_queue: q_count=%0d want 1", q_count); end
        pwr(OP_ADDI, 5'd3, 32'hBB, 32'h0); md_valid = 1'b0; step();
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count} !== {1'b1, 5'd3, 32'hBB, 3'd1}) begin
            errors++; $display("FAIL sq_pipe: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count}, {1'b1, 5'd3, 32'hBB, 3'd1}); end
        idle(); step();
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count} !== {1'b0, 5'd3, 32'hBB, 3'd0}) begin
            errors++; $display("FAIL sq_pop: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count}, {1'b0, 5'd3, 32'hBB, 3'd0}); end
        pwr(OP_ADDI, 5'd3, 32'hCC, 32'h0); md(5'd3, 32'hAA); step();
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count} !== {1'b1, 5'd3, 32'hCC, 3'd1}) begin
            errors++; $display("FAIL sq_same_pipe: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count}, {1'b1, 5'd3, 32'hCC, 3'd1}); end
        idle(); step();
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count} !== {1'b0, 5'd3, 32'hCC, 3'd0}) begin
            errors++; $display("FAIL sq_same_pop: got %h want %h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg, q_count}, {1'b0, 5'd3, 32'hCC, 3'd0}); end
    endtask

    task automatic test_back_to_back;
        pwr(OP_ADDI, 5'd1, 32'h1, 32'h0); md(5'd16, 32'h100); step();
        md(5'd17, 32'h101); step();
        checks++; if (q_count !== 3'd2) begin
            errors++; $display("FAIL b2b_fill: q_count=%0d want 2", q_count); end
        pipe_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            md(5'(18 + k), 32'h102 + k); step();
            checks++; if ({q_count, ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {3'd2, 1'b1, 5'(16 + k), 32'h100 + k}) begin
                errors++; $display("FAIL b2b_op%0d: got %h want %h", k, {q_count, ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {3'd2, 1'b1, 5'(16 + k), 32'h100 + k}); end
        end
        idle();
        for (int k = 10; k < 12; k++) begin
            step();
            checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'(16 + k), 32'h100 + k}) begin
                errors++; $display("FAIL b2b_tail%0d: got %h want %h", k, {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'(16 + k), 32'h100 + k}); end
        end
        step();
        checks++; if ({ctrl_writeEnable, q_count} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL b2b_empty: we=%0b q_count=%0d want 0/0", ctrl_writeEnable, q_count); end
    endtask

    task automatic test_mid_reset;
        pwr(OP_ADDI, 5'd1, 32'h1, 32'h0); md(5'd5, 32'h5); step();
        md(5'd6, 32'h6); step();
        checks++; if ({ctrl_writeEnable, q_count} !== {1'b1, 3'd2}) begin
            errors++; $display("FAIL mrst_pre: we=%0b q_count=%0d want 1/2", ctrl_writeEnable, q_count); end
        idle();
        #3 reset = 1'b0;
        #1;
        checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== 38'd0) begin
            errors++; $display("FAIL mrst_out: got %h want 0", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}); end
        checks++; if ({q_count, md_ready} !== {3'd0, 1'b1}) begin
            errors++; $display("FAIL mrst_q: q_count=%0d md_ready=%0b want 0/1", q_count, md_ready); end
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({ctrl_writeEnable, q_count} !== {1'b0, 3'd0}) begin
                errors++; $display("FAIL mrst_stale%0d: we=%0b q_count=%0d want 0/0", i, ctrl_writeEnable, q_count); end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_drain();
        test_full();
        test_md_dest();
        test_squash();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_write_arb.md
Name: stage_write_arb

Overview:
Parametrised writeback stage that merges the in-order pipeline writeback with out-of-order multdiv completions onto the single regfile write port. It decodes the writeback-stage instruction and buffers multdiv results in a QDEPTH-entry FIFO. Queued results drain on cycles when the pipeline does not write. Outputs are registered, and WAW ordering against queued results is enforced by squashing them.

Parameters:
DATA_W, 32, width of regfile data
REG_AW, 5, regfile address width (register 31 = link, register 30 = rstatus)
QDEPTH, 4, multdiv completion FIFO depth (power of two, >= 2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
pipe_valid  in  1  writeback-stage slot holds a real instruction
pipe_insn  in  32  writeback-stage instruction (opcode [31:27], rd [26:22], ALU op [6:2])
pipe_o  in  DATA_W  ALU/PC+1 result
pipe_d  in  DATA_W  dmem read data
pipe_exception  in  1  pipeline instruction raised an exception; redirect its write to register 30
md_valid  in  1  multdiv completion strobe
md_rd  in  REG_AW  multdiv destination
md_data  in  DATA_W  multdiv result, or status code when md_exception is 1
md_exception  in  1  multdiv exception; redirect its write to register 30
md_ready  out  1  FIFO can accept a completion this cycle
data_writeReg  out  DATA_W  registered write data
ctrl_writeReg  out  REG_AW  registered write address
ctrl_writeEnable  out  1  registered write enable
q_count  out  $clog2(QDEPTH+1)  FIFO occupancy, including squashed entries

Behaviour:
- Reset (reset = 0, asynchronous): ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0. FIFO pointers and all entry valid bits clear, q_count = 0, md_ready = 1. Reset mid-drain discards all queued entries.
- Pipeline decode:
  - Writing opcodes: R-type 00000, addi 00101, lw 01000, jal 00011, setx 10101.
  - pipe_we = pipe_valid & writing opcode & (dest != 0).
  - Destination priority: jal -> 31; else exception or setx -> 30; else rd.
  - Data: lw -> pipe_d; else pipe_o.
- Arbitration, per cycle:
  - If pipe_we: the output registers load the pipeline write next edge. No pop occurs.
  - Else if the FIFO is non-empty: pop the head. If the head is valid, the output registers load its address and data with enable 1. If the head is squashed, enable 0.
  - Else: enable 0. Address and data hold their previous values.
- Latency: exactly 1 cycle from input to registered output for pipeline writes. A queued entry reaches the output 1 cycle after it is popped.
- Enqueue:
  - md_ready = (q_count < QDEPTH), based on current occupancy only. A same-cycle pop does not free a slot for that cycle's push.
  - md_valid & md_ready pushes {dest, data, valid}, where dest = md_exception ? 30 : md_rd.
  - md_valid with md_rd = 0 and no exception is dropped; nothing is pushed.
  - md_valid while md_ready = 0 is a protocol error. The completion is dropped and state is unchanged.
- Push and pop in the same cycle: both occur; q_count is unchanged.
- Pointer wrap: modulo QDEPTH.
- WAW squash:
  - When pipe_we and the pipeline dest equals the dest of any valid queued entry, those entries' valid bits clear on the next edge.
  - An md completion pushed in the same cycle with the same dest is pushed with valid = 0.
  - Rationale: a queued multdiv result is older in program order than the pipeline instruction, so it must not overwrite the newer value.
- Squashed entries still occupy FIFO slots until popped. Popping a squashed entry costs one idle write cycle.

Test Plan:
- Reset: assert reset low mid-cycle with 2 entries queued -> enable, address and data = 0 immediately; q_count = 0; md_ready = 1. After release, no stale writes appear.
- Decode: pipeline jal with pipe_o = 0x40 -> next cycle writes reg 31 with 0x40. lw rd = 5 with pipe_d = 0xDEAD -> writes reg 5 with 0xDEAD. add with rd = 0 -> enable 0. R-type with pipe_exception -> writes reg 30.
- Drain: push md rd = 7 (data 0x11) and rd = 9 (data 0x22) while the pipeline writes for 3 cycles -> q_count reaches 2 and nothing drains. Pipeline goes idle -> reg 7 = 0x11, then reg 9 = 0x22 on consecutive cycles; q_count goes 2, 1, 0.
- Full: QDEPTH = 4 with the pipeline writing continuously, 4 pushes -> md_ready = 0 and q_count = 4. A 5th md_valid is dropped. After one idle pipeline cycle, md_ready returns to 1.
- Squash: queue rd = 3 (0xAA), then pipeline addi rd = 3 writes 0xBB -> reg 3 = 0xBB. The later pop gives enable 0, and reg 3 is never written with 0xAA. Repeat with the md push in the same cycle as the pipeline write -> same result.
- Simultaneous push and pop at q_count = 2 -> q_count stays 2; FIFO order is preserved across pointer wrap over 10 operations.
